// File: rtl/gen_burst_pkg.sv
// rtl/gen_burst_pkg.sv - state encoding and default constants for gen_burst_scheduler
package gen_burst_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SPACE,
    TRIG,
    WAIT_FIRST,
    STREAM,
    GAP
  } state_t;

  localparam int DEF_BURST_LEN  = 1024;
  localparam int DEF_FIFO_AW    = 12;
  localparam int DEF_GAP_CYCLES = 16;
  localparam int DEF_FIRST_TMO  = 8;

endpackage

// File: rtl/gen_burst_scheduler.sv
// rtl/gen_burst_scheduler.sv - burst trigger FSM for the pattern generator; GEN_BURST_SCHED_STALL_CNT_EN adds the stall counter
module gen_burst_scheduler
  import gen_burst_pkg::*;
#(
  parameter int BURST_LEN  = DEF_BURST_LEN,
  parameter int FIFO_AW    = DEF_FIFO_AW,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int FIRST_TMO  = DEF_FIRST_TMO
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               start,
  input  logic               stop,
  input  logic [15:0]        burst_num,
  input  logic [FIFO_AW:0]   fifo_used,
  input  logic               gen_tx_write,
  output logic               gen_trigger,
  output logic               busy,
  output logic               done,
  output logic [15:0]        bursts_done,
  output logic               tmo_err,
  output logic               proto_err,
  output logic [31:0]        stall_cycles
);

  localparam int BW = $clog2(BURST_LEN + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int TW = $clog2(FIRST_TMO + 1);
  localparam logic [FIFO_AW+1:0] LP_BURST = (FIFO_AW+2)'(BURST_LEN);
  localparam logic [FIFO_AW+1:0] LP_DEPTH = (FIFO_AW+2)'(2**FIFO_AW);

  state_t          r_state;
  logic            r_gen_trigger;
  logic            r_done;
  logic            r_tmo_err;
  logic            r_proto_err;
  logic            r_stop_flag;
  logic [15:0]     r_burst_num;
  logic [15:0]     r_bursts_done;
  logic [BW-1:0]   r_beat_cnt;
  logic [GW-1:0]   r_gap_cnt;
  logic [TW-1:0]   r_tmo_cnt;

  logic            w_space;
  logic            w_end_of_run;

  // One extra bit on the sum so a nearly full FIFO cannot wrap and look empty
  assign w_space      = (({1'b0, fifo_used} + LP_BURST) <= LP_DEPTH);
  assign w_end_of_run = r_stop_flag || stop ||
                        ((r_burst_num != 16'd0) && (r_bursts_done == r_burst_num));

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state       <= IDLE;
      r_gen_trigger <= 1'b0;
      r_done        <= 1'b0;
      r_tmo_err     <= 1'b0;
      r_proto_err   <= 1'b0;
      r_stop_flag   <= 1'b0;
      r_burst_num   <= '0;
      r_bursts_done <= '0;
      r_beat_cnt    <= '0;
      r_gap_cnt     <= '0;
      r_tmo_cnt     <= '0;
    end else begin
      r_gen_trigger <= 1'b0;
      r_done        <= 1'b0;
      if (gen_tx_write && (r_state inside {IDLE, WAIT_SPACE, TRIG, GAP}))
        r_proto_err <= 1'b1;
      if (stop && (r_state != IDLE))
        r_stop_flag <= 1'b1;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_burst_num   <= burst_num;
            r_bursts_done <= '0;
            r_stop_flag   <= stop;
            r_state       <= WAIT_SPACE;
          end
        end
        WAIT_SPACE: begin
          if (stop) begin
            r_done  <= 1'b1;
            r_state <= IDLE;
          end else if (w_space) begin
            r_gen_trigger <= 1'b1;
            r_state       <= TRIG;
          end
        end
        TRIG: begin
          r_beat_cnt <= '0;
          r_tmo_cnt  <= '0;
          r_state    <= WAIT_FIRST;
        end
        WAIT_FIRST: begin
          if (gen_tx_write) begin
            r_beat_cnt <= BW'(1);
            r_state    <= STREAM;
          end else if (r_tmo_cnt == TW'(FIRST_TMO - 1)) begin
            r_tmo_err <= 1'b1;
            r_done    <= 1'b1;
            r_state   <= IDLE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        STREAM: begin
          if (gen_tx_write) begin
            if (r_beat_cnt == BW'(BURST_LEN - 1)) begin
              r_bursts_done <= r_bursts_done + 16'd1;
              r_gap_cnt     <= '0;
              r_state       <= GAP;
            end else begin
              r_beat_cnt <= r_beat_cnt + 1'b1;
            end
          end
        end
        GAP: begin
          if (r_gap_cnt == GW'(GAP_CYCLES - 1)) begin
            if (w_end_of_run) begin
              r_done  <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_state <= WAIT_SPACE;
            end
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef GEN_BURST_SCHED_STALL_CNT_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)
      r_stall_cycles <= '0;
    else if ((r_state == IDLE) && start)
      r_stall_cycles <= '0;
    else if ((r_state == WAIT_SPACE) && !w_space && (r_stall_cycles != 32'hFFFF_FFFF))
      r_stall_cycles <= r_stall_cycles + 32'd1;
  end

  assign stall_cycles = r_stall_cycles;
`else
  assign stall_cycles = '0;
`endif

  assign gen_trigger = r_gen_trigger;
  assign busy        = (r_state != IDLE);
  assign done        = r_done;
  assign bursts_done = r_bursts_done;
  assign tmo_err     = r_tmo_err;
  assign proto_err   = r_proto_err;

endmodule
